// File: rtl/qu_instr_decoder.sv
// qu_instr_decoder
// ----------------
// Decode stage of the Qu front end. Takes an RV32I instruction word plus its
// PC from fetch, splits out register/function fields, builds the sign- or
// zero-extended immediate, classifies the instruction and flags illegal
// encodings. Decoded entries leave through a registered valid/ready interface
// backed by a main register and a skid register (2-entry FIFO).
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   flush               drop every buffered entry and any same-cycle input
//   in_valid/in_ready   fetch handshake (in_ready is registered)
//   in_instr, in_pc     instruction word and its PC
//   out_valid/out_ready rename/dispatch handshake
//   out_pc, out_class   PC and class (R=0 .. FENCE=10, ILLEGAL=15)
//   out_rd/rs1/rs2      raw register fields, with *_valid "field is used"
//   out_funct3/funct7   raw function fields
//   out_imm             decoded immediate
//   out_illegal         illegal encoding marker
module qu_instr_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [11:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_pc,
  output logic [3:0]  out_class,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic        out_rd_valid,
  output logic        out_rs1_valid,
  output logic        out_rs2_valid,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [31:0] out_imm,
  output logic        out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [3:0] CLS_R       = 4'd0;
  localparam logic [3:0] CLS_I       = 4'd1;
  localparam logic [3:0] CLS_LOAD    = 4'd2;
  localparam logic [3:0] CLS_STORE   = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_JAL     = 4'd5;
  localparam logic [3:0] CLS_JALR    = 4'd6;
  localparam logic [3:0] CLS_LUI     = 4'd7;
  localparam logic [3:0] CLS_AUIPC   = 4'd8;
  localparam logic [3:0] CLS_SYSTEM  = 4'd9;
  localparam logic [3:0] CLS_FENCE   = 4'd10;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  typedef struct packed {
    logic [11:0] pc;
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_v;
    logic        rs1_v;
    logic        rs2_v;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  // Raw fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  // Per-format immediates
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh, imm_sys;

  assign imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u   = {in_instr[31:12], 12'd0};
  assign imm_sh  = {27'd0, in_instr[24:20]};
  assign imm_sys = {20'd0, in_instr[31:20]};

  logic [3:0]  cls_s;
  logic [31:0] imm_s_sel;
  logic        rd_use_s, rs1_use_s, rs2_use_s, bad_s;
  dec_t        dec_s;

  // Opcode classification, immediate selection and legality checks
  always_comb begin
    cls_s     = CLS_ILLEGAL;
    imm_s_sel = 32'd0;
    rd_use_s  = 1'b0;
    rs1_use_s = 1'b0;
    rs2_use_s = 1'b0;
    bad_s     = 1'b0;
    case (opcode)
      OPC_OP: begin
        cls_s     = CLS_R;
        rd_use_s  = 1'b1;
        rs1_use_s = 1'b1;
        rs2_use_s = 1'b1;
        if (funct7 == 7'b0000000) begin
          bad_s = 1'b0;
        end else if (funct7 == 7'b0100000) begin
          // only SUB (funct3 0) and SRA (funct3 5) use the alternate funct7
          bad_s = !((funct3 == 3'd0) || (funct3 == 3'd5));
        end else begin
          bad_s = 1'b1;
        end
      end
      OPC_OPIMM: begin
        cls_s     = CLS_I;
        rd_use_s  = 1'b1;
        rs1_use_s = 1'b1;
        if (funct3 == 3'd1) begin
          imm_s_sel = imm_sh;
          bad_s     = (funct7 != 7'b0000000);
        end else if (funct3 == 3'd5) begin
          imm_s_sel = imm_sh;
          bad_s     = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
        end else begin
          imm_s_sel = imm_i;
          bad_s     = 1'b0;
        end
      end
      OPC_LOAD: begin
        cls_s     = CLS_LOAD;
        rd_use_s  = 1'b1;
        rs1_use_s = 1'b1;
        imm_s_sel = imm_i;
        bad_s     = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        cls_s     = CLS_STORE;
        rs1_use_s = 1'b1;
        rs2_use_s = 1'b1;
        imm_s_sel = imm_s;
        bad_s     = (funct3 > 3'd2);
      end
      OPC_BRANCH: begin
        cls_s     = CLS_BRANCH;
        rs1_use_s = 1'b1;
        rs2_use_s = 1'b1;
        imm_s_sel = imm_b;
        bad_s     = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_JAL: begin
        cls_s     = CLS_JAL;
        rd_use_s  = 1'b1;
        imm_s_sel = imm_j;
      end
      OPC_JALR: begin
        cls_s     = CLS_JALR;
        rd_use_s  = 1'b1;
        rs1_use_s = 1'b1;
        imm_s_sel = imm_i;
        bad_s     = (funct3 != 3'd0);
      end
      OPC_LUI: begin
        cls_s     = CLS_LUI;
        rd_use_s  = 1'b1;
        imm_s_sel = imm_u;
      end
      OPC_AUIPC: begin
        cls_s     = CLS_AUIPC;
        rd_use_s  = 1'b1;
        imm_s_sel = imm_u;
      end
      OPC_SYSTEM: begin
        cls_s     = CLS_SYSTEM;
        imm_s_sel = imm_sys;
        if (funct3 == 3'd0) begin
          // ECALL (0) / EBREAK (1) are the only legal selectors
          bad_s = (in_instr[31:20] > 12'd1);
        end else if (funct3 == 3'd4) begin
          bad_s = 1'b1;
        end else begin
          // CSR ops; the immediate forms carry a uimm in the rs1 slot
          rd_use_s  = 1'b1;
          rs1_use_s = (funct3 <= 3'd3);
        end
      end
      OPC_FENCE: begin
        cls_s = CLS_FENCE;
        bad_s = (funct3 > 3'd1);
      end
      default: begin
        bad_s = 1'b1;
      end
    endcase
    if (in_instr[1:0] != 2'b11) begin
      bad_s = 1'b1;
    end else begin
      bad_s = bad_s;
    end
  end

  // Assemble the entry; illegal encodings keep raw fields and PC only
  always_comb begin
    dec_s.pc      = in_pc;
    dec_s.rd      = rd;
    dec_s.rs1     = rs1;
    dec_s.rs2     = rs2;
    dec_s.funct3  = funct3;
    dec_s.funct7  = funct7;
    if (bad_s) begin
      dec_s.cls     = CLS_ILLEGAL;
      dec_s.imm     = 32'd0;
      dec_s.rd_v    = 1'b0;
      dec_s.rs1_v   = 1'b0;
      dec_s.rs2_v   = 1'b0;
      dec_s.illegal = 1'b1;
    end else begin
      dec_s.cls     = cls_s;
      dec_s.imm     = imm_s_sel;
      dec_s.rd_v    = rd_use_s && (rd != 5'd0);
      dec_s.rs1_v   = rs1_use_s;
      dec_s.rs2_v   = rs2_use_s;
      dec_s.illegal = 1'b0;
    end
  end

  // Output buffering: main register feeds out_*, skid catches one stalled entry
  dec_t main_q, main_d, skid_q, skid_d;
  logic main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic in_ready_q, in_ready_d;
  logic accept_s, pop_s;

  assign accept_s = in_valid && in_ready_q;
  assign pop_s    = main_vld_q && out_ready;

  // Next-state for the two-entry FIFO; flush wins over everything
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // in_ready is low, so no input can arrive; only drain skid into main
      if (pop_s) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        skid_vld_d = 1'b1;
      end
    end else if (!main_vld_q || pop_s) begin
      if (accept_s) begin
        main_d     = dec_s;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else begin
      // main held by a stalled consumer: a new entry parks in skid
      if (accept_s) begin
        skid_d     = dec_s;
        skid_vld_d = 1'b1;
      end else begin
        skid_vld_d = 1'b0;
      end
    end
    in_ready_d = !skid_vld_d;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_vld_q;
  assign out_pc        = main_q.pc;
  assign out_class     = main_q.cls;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_rd_valid  = main_q.rd_v;
  assign out_rs1_valid = main_q.rs1_v;
  assign out_rs2_valid = main_q.rs2_v;
  assign out_funct3    = main_q.funct3;
  assign out_funct7    = main_q.funct7;
  assign out_imm       = main_q.imm;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_qu_instr_decoder.sv
// Directed bench for qu_instr_decoder: decode vectors, backpressure,
// flush and asynchronous mid-stream reset.
module tb_qu_instr_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic [11:0] in_pc = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_pc;
  logic [3:0]  out_class;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_rd_valid, out_rs1_valid, out_rs2_valid;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        out_illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qu_instr_decoder dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_class(out_class),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd_valid(out_rd_valid), .out_rs1_valid(out_rs1_valid),
    .out_rs2_valid(out_rs2_valid),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [11:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  // vld = {rd_valid, rs1_valid, rs2_valid}
  task automatic check_dec(input string tag, input logic [3:0] cls, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] vld,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                           input logic ill, input logic [11:0] pc);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".class"}, {28'd0, out_class}, {28'd0, cls});
    check({tag, ".rd"}, {27'd0, out_rd}, {27'd0, rd});
    check({tag, ".rs1"}, {27'd0, out_rs1}, {27'd0, rs1});
    check({tag, ".rs2"}, {27'd0, out_rs2}, {27'd0, rs2});
    check({tag, ".vld"}, {29'd0, out_rd_valid, out_rs1_valid, out_rs2_valid}, {29'd0, vld});
    check({tag, ".f3"}, {29'd0, out_funct3}, {29'd0, f3});
    check({tag, ".f7"}, {25'd0, out_funct7}, {25'd0, f7});
    check({tag, ".imm"}, out_imm, imm);
    check({tag, ".ill"}, {31'd0, out_illegal}, {31'd0, ill});
    check({tag, ".pc"}, {20'd0, out_pc}, {20'd0, pc});
  endtask

  initial begin
    // ---- reset state ----
    #6;
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.class", {28'd0, out_class}, 32'd0);
    check("rst.imm", out_imm, 32'd0);
    check("rst.pc", {20'd0, out_pc}, 32'd0);
    #6;
    rst = 1'b0;
    tick;

    // ---- decode vectors, streaming at one per cycle ----
    out_ready = 1'b1;
    drive(1'b1, 32'h002081B3, 12'h010); tick;
    check_dec("add",   4'd0,  5'd3,  5'd1,  5'd2,  3'b111, 3'd0, 7'h00, 32'h00000000, 1'b0, 12'h010);
    drive(1'b1, 32'hFE20AE23, 12'h014); tick;
    check_dec("sw",    4'd3,  5'd28, 5'd1,  5'd2,  3'b011, 3'd2, 7'h7F, 32'hFFFFFFFC, 1'b0, 12'h014);
    drive(1'b1, 32'hFE000CE3, 12'h018); tick;
    check_dec("beq",   4'd4,  5'd25, 5'd0,  5'd0,  3'b011, 3'd0, 7'h7F, 32'hFFFFFFF8, 1'b0, 12'h018);
    drive(1'b1, 32'hFFF30293, 12'h01C); tick;
    check_dec("addi",  4'd1,  5'd5,  5'd6,  5'd31, 3'b110, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0, 12'h01C);
    drive(1'b1, 32'h40315093, 12'h020); tick;
    check_dec("srai",  4'd1,  5'd1,  5'd2,  5'd3,  3'b110, 3'd5, 7'h20, 32'h00000003, 1'b0, 12'h020);
    drive(1'b1, 32'h123453B7, 12'h024); tick;
    check_dec("lui",   4'd7,  5'd7,  5'd8,  5'd3,  3'b100, 3'd5, 7'h09, 32'h12345000, 1'b0, 12'h024);
    drive(1'b1, 32'hFFDFF06F, 12'h028); tick;
    check_dec("jal",   4'd5,  5'd0,  5'd31, 5'd29, 3'b000, 3'd7, 7'h7F, 32'hFFFFFFFC, 1'b0, 12'h028);
    drive(1'b1, 32'h3005A573, 12'h02C); tick;
    check_dec("csrrs", 4'd9,  5'd10, 5'd11, 5'd0,  3'b110, 3'd2, 7'h18, 32'h00000300, 1'b0, 12'h02C);
    drive(1'b1, 32'h00000073, 12'h030); tick;
    check_dec("ecall", 4'd9,  5'd0,  5'd0,  5'd0,  3'b000, 3'd0, 7'h00, 32'h00000000, 1'b0, 12'h030);
    drive(1'b1, 32'h00200073, 12'h034); tick;
    check_dec("badsys",4'd15, 5'd0,  5'd0,  5'd2,  3'b000, 3'd0, 7'h00, 32'h00000000, 1'b1, 12'h034);
    drive(1'b1, 32'h00000000, 12'h038); tick;
    check_dec("zero",  4'd15, 5'd0,  5'd0,  5'd0,  3'b000, 3'd0, 7'h00, 32'h00000000, 1'b1, 12'h038);
    drive(1'b1, 32'h0000707F, 12'h03C); tick;
    check_dec("badopc",4'd15, 5'd0,  5'd0,  5'd0,  3'b000, 3'd7, 7'h00, 32'h00000000, 1'b1, 12'h03C);
    drive(1'b1, 32'h40001033, 12'h040); tick;
    check_dec("badr",  4'd15, 5'd0,  5'd0,  5'd0,  3'b000, 3'd1, 7'h20, 32'h00000000, 1'b1, 12'h040);
    drive(1'b0, 32'd0, 12'h000); tick;
    check("idle.out_valid", {31'd0, out_valid}, 32'd0);

    // ---- backpressure: 4 ADDIs, consumer stalled for 3 cycles ----
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 12'h100); tick;
    check("bp1.in_ready", {31'd0, in_ready}, 32'd1);
    check("bp1.imm", out_imm, 32'd1);
    drive(1'b1, 32'h00200093, 12'h104); tick;
    check("bp2.in_ready", {31'd0, in_ready}, 32'd0);
    check("bp2.imm", out_imm, 32'd1);
    drive(1'b1, 32'h00300093, 12'h108); tick;
    check("bp3.in_ready", {31'd0, in_ready}, 32'd0);
    check("bp3.imm", out_imm, 32'd1);
    check("bp3.pc", {20'd0, out_pc}, 32'h100);
    out_ready = 1'b1; tick;
    check("bp4.valid", {31'd0, out_valid}, 32'd1);
    check("bp4.imm", out_imm, 32'd2);
    check("bp4.in_ready", {31'd0, in_ready}, 32'd1);
    tick;
    check("bp5.imm", out_imm, 32'd3);
    check("bp5.pc", {20'd0, out_pc}, 32'h108);
    drive(1'b1, 32'h00400093, 12'h10C); tick;
    check("bp6.imm", out_imm, 32'd4);
    check("bp6.pc", {20'd0, out_pc}, 32'h10C);
    drive(1'b0, 32'd0, 12'h000); tick;
    check("bp7.valid", {31'd0, out_valid}, 32'd0);

    // ---- flush with both entries full and in_valid high ----
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 12'h200); tick;
    drive(1'b1, 32'h00200093, 12'h204); tick;
    check("fl.full.in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h00300093, 12'h208);
    flush = 1'b1; out_ready = 1'b1; tick;
    flush = 1'b0;
    check("fl.out_valid", {31'd0, out_valid}, 32'd0);
    check("fl.in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h00500093, 12'h20C); tick;
    check("fl.next.valid", {31'd0, out_valid}, 32'd1);
    check("fl.next.imm", out_imm, 32'd5);
    check("fl.next.pc", {20'd0, out_pc}, 32'h20C);
    // flush while an input handshakes: that input must be discarded
    drive(1'b1, 32'h00600093, 12'h210);
    flush = 1'b1; tick;
    flush = 1'b0;
    drive(1'b0, 32'd0, 12'h000);
    check("fl2.out_valid", {31'd0, out_valid}, 32'd0);
    tick;
    check("fl2.no_stale", {31'd0, out_valid}, 32'd0);

    // ---- asynchronous reset mid-stream ----
    out_ready = 1'b0;
    drive(1'b1, 32'h00700093, 12'h300); tick;
    drive(1'b1, 32'h00800093, 12'h304); tick;
    #3 rst = 1'b1;
    #1;
    check("ar.out_valid", {31'd0, out_valid}, 32'd0);
    check("ar.in_ready", {31'd0, in_ready}, 32'd1);
    check("ar.imm", out_imm, 32'd0);
    check("ar.pc", {20'd0, out_pc}, 32'd0);
    check("ar.class", {28'd0, out_class}, 32'd0);
    check("ar.rd", {27'd0, out_rd}, 32'd0);
    drive(1'b0, 32'd0, 12'h000);
    out_ready = 1'b1;
    #2 rst = 1'b0;
    tick;
    check("ar.no_stale", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 32'h00900093, 12'h308); tick;
    check("ar.after.imm", out_imm, 32'd9);
    check("ar.after.pc", {20'd0, out_pc}, 32'h308);
    drive(1'b0, 32'd0, 12'h000); tick;
    check("ar.after.drain", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qu_instr_decoder.md
# qu_instr_decoder

Decode stage of the Qu front end. Accepts 32-bit RV32I instruction words with their PC from fetch, splits them into register, function and immediate fields, sign-extends the immediate, classifies the instruction and flags illegal encodings. It is the inverse of the `qu_common` encoding functions. Results pass to rename/dispatch through a registered valid/ready interface backed by a 2-entry skid buffer.

## Interface
- `QU_INSTR_WIDTH`, 32, instruction width (from `qu_common`)
- `QU_PC_WIDTH`, 12, PC width (from `qu_common`)
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  discard all buffered instructions (branch mispredict)
- `in_valid`  in  1  fetch holds a valid instruction
- `in_ready`  out  1  decoder accepts the instruction this cycle
- `in_instr`  in  32  instruction word (`instr_t`)
- `in_pc`  in  12  PC of the instruction (`pc_t`)
- `out_valid`  out  1  decoded entry present
- `out_ready`  in  1  consumer takes the entry this cycle
- `out_pc`  out  12  PC of the decoded instruction
- `out_class`  out  4  R=0, I=1, LOAD=2, STORE=3, BRANCH=4, JAL=5, JALR=6, LUI=7, AUIPC=8, SYSTEM=9, FENCE=10, ILLEGAL=15
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register fields
- `out_rd_valid`, `out_rs1_valid`, `out_rs2_valid`  out  1 each  the field is used
- `out_funct3`  out  3;  `out_funct7`  out  7
- `out_imm`  out  32  decoded immediate
- `out_illegal`  out  1  illegal encoding

## Operation
- Decode is combinational on `in_instr`. The result, together with `in_pc`, is captured into the output register on the input handshake (`in_valid & in_ready`).
- Immediate decode by format:
  - I/LOAD/JALR: sext `instr[31:20]`
  - Shift-immediate (SLLI, SRLI, SRAI): zero-extended `instr[24:20]`
  - S: sext `{instr[31:25], instr[11:7]}`
  - B: sext `{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}`
  - JAL: sext `{instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}`
  - LUI/AUIPC: `{instr[31:12], 12'b0}`
  - SYSTEM: zero-extended `instr[31:20]` (CSR address or ECALL/EBREAK selector)
  - R/FENCE: 0
- Register-field use:
  - `rs1_valid` for R, I, LOAD, STORE, BRANCH, JALR, and CSRRW/CSRRS/CSRRC
  - `rs2_valid` for R, STORE, BRANCH
  - `rd_valid` for R, I, LOAD, JAL, JALR, LUI, AUIPC, and CSR instructions, and forced to 0 when `rd == 0`
- An encoding is illegal when any of the following holds:
  - `instr[1:0] != 2'b11`
  - the opcode is not one of the 11 defined opcodes
  - R format with `funct7` other than `0000000`/`0100000`, or `0100000` with `funct3` other than ADD/SRA
  - SLLI with nonzero `funct7`; SRLI/SRAI with `funct7` other than `0000000`/`0100000`
  - LOAD with `funct3` of 3, 6 or 7
  - STORE with `funct3 > 2`
  - BRANCH with `funct3` of 2 or 3
  - JALR with `funct3 != 0`
  - SYSTEM with `funct3 == 0` and `imm` other than 0 or 1, or with `funct3 == 4`
  - FENCE with `funct3 > 1`
- Illegal entries carry `out_class = 15`, `out_illegal = 1`, all `*_valid = 0` and `out_imm = 0`, with `pc` and the raw fields preserved. They still flow through so the ROB can raise the exception in order.
- Buffering uses a main register plus a skid register:
  - `in_ready` = skid register empty.
  - When the consumer stalls while an input is accepted, the new entry goes to the skid register.
  - When the main register drains, the skid entry moves to main.
  - Order is strictly FIFO; no entry is dropped or duplicated.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on `out_*` after edge N.
- Throughput is 1 instruction per cycle while `out_ready = 1`.
- `in_ready` is a registered output (no combinational path from `out_ready`). It drops the cycle after the skid register fills and rises the cycle after it empties.
- `out_*` are stable while `out_valid & !out_ready`.
- `flush` at edge N:
  - Both entries are invalidated; `out_valid = 0` and `in_ready = 1` after N.
  - An input handshaking in the same cycle is discarded.
  - `flush` takes priority over `out_ready`.
- Reset, including assertion mid-stream: `out_valid = 0`, `in_ready = 1`, skid empty, all data outputs 0, and `out_class = 0`. In-flight entries are lost.
- With `in_valid` and `out_ready` both high and both entries full, one entry leaves, skid moves to main, and the input is not accepted (`in_ready` is 0 that cycle).

## Test plan
- `0x002081B3` (ADD x3,x1,x2) at pc `0x010` → one cycle later: class 0, rd 3, rs1 1, rs2 2, all valids 1, funct3 0, funct7 0, imm 0, `out_pc = 0x010`.
- `0xFE20AE23` (SW x2,-4(x1)) → class 3, rs1 1, rs2 2, funct3 2, `imm = 0xFFFFFFFC`, `rd_valid = 0`. `0xFE000CE3` (BEQ x0,x0,-8) → class 4, `imm = 0xFFFFFFF8`.
- Backpressure: stream 4 ADDIs with `out_ready = 0` for 3 cycles →
  - `in_ready` falls after the 2nd accept;
  - the 3rd instruction waits;
  - after release, all 4 emerge in order with no gaps or duplicates.
- `0x00000000` and `0x0000707F` (bad opcode) → class 15, `out_illegal = 1`, valids 0, imm 0.
- `flush` asserted with both entries full and `in_valid = 1` → next cycle `out_valid = 0`, `in_ready = 1`; the next instruction after the flush emerges normally.
- `rst` pulsed asynchronously mid-stream (not edge-aligned) → outputs cleared immediately; no stale entry appears after release.
